uart_tx_ctrl: RTL and testbench

UART transmit controller that sequences the 8-bit serializer into a complete frame: start bit, 8 data bits LSB-first, optional parity bit, stop bit. It accepts a parallel byte on a valid strobe and latches the byte and the parity configuration. It drives the serializer's enable and parallel-data inputs, computes parity, and muxes start/data/parity/stop levels onto the serial line. It sits between the system-side byte source and the TX pin, with the serializer as its only datapath resource.

---
 rtl/uart_tx_ctrl.sv | 84 ++++++++
 tb/tb_uart_tx_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a latched byte as start, 8 data bits LSB-first,
// optional parity and stop, driving the external 8-bit serializer during the data phase.
module uart_tx_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] P_DATA,
   input  logic       Data_Valid,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   input  logic       ser_done,
   input  logic       ser_data,
   output logic       ser_en,
   output logic [7:0] ser_data_in,
   output logic       TX_OUT,
   output logic       busy
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] data_q;
   logic       par_en_q;
   logic       par_typ_q;
   logic       accept;

   // A new byte may only be taken when the line is idle or finishing its stop bit.
   assign accept = Data_Valid && ((state_q == StIdle) || (state_q == StStop));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         data_q    <= 8'h00;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ser_en  = 1'b0;
      TX_OUT  = 1'b1;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = StStart;
         end
         StStart: begin
            TX_OUT  = 1'b0;
            state_d = StData;
         end
         StData: begin
            ser_en = 1'b1;
            TX_OUT = ser_data;
            if (ser_done) state_d = par_en_q ? StParity : StStop;
         end
         StParity: begin
            TX_OUT  = (^data_q) ^ par_typ_q;
            state_d = StStop;
         end
         StStop: begin
            state_d = accept ? StStart : StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy        = (state_q != StIdle);
   assign ser_data_in = data_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a simple serializer model feeds the DUT and each
// frame is checked bit-by-bit against a queue built from the byte and parity settings.
module tb_uart_tx_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       ser_done;
   logic       ser_data;
   logic       ser_en;
   logic [7:0] ser_data_in;
   logic       TX_OUT;
   logic       busy;

   int vectors = 0;
   int errors  = 0;

   uart_tx_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .ser_done   (ser_done),
      .ser_data   (ser_data),
      .ser_en     (ser_en),
      .ser_data_in(ser_data_in),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Serializer stand-in: counter clears whenever ser_en is low, presents bit cnt of the byte.
   logic [2:0] scnt;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        scnt <= 3'd0;
      else if (ser_en) scnt <= scnt + 3'd1;
      else             scnt <= 3'd0;
   end
   assign ser_data = ser_data_in[scnt];
   assign ser_done = ser_en && (scnt == 3'd7);

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_check(input int n, input logic [7:0] exp_sdi);
      Data_Valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         P_DATA  = 8'($urandom);
         PAR_EN  = 1'($urandom);
         PAR_TYP = 1'($urandom);
         @(negedge clk);
         check("idle_tx", TX_OUT, 1'b1);
         check("idle_busy", busy, 1'b0);
         check("idle_ser_en", ser_en, 1'b0);
         check("idle_sdi", ser_data_in, exp_sdi);
         @(posedge clk); #1;
      end
   endtask

   task automatic launch(input logic [7:0] b, input logic pe, input logic pt);
      Data_Valid = 1'b1;
      P_DATA     = b;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      @(posedge clk); #1;
   endtask

   // Called one step after the accept edge. mode: 0 = DV low, 1 = DV held high,
   // 2 = random input noise, 3 = clobber data/parity inputs. Last cycle sets up the next frame.
   task automatic frame(input logic [7:0] b, input logic pe, input logic pt, input int mode,
                        input logic nxt_dv, input logic [7:0] nb, input logic npe,
                        input logic npt);
      logic exp_q[$];
      exp_q = {1'b0};
      for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
      if (pe) exp_q.push_back((^b) ^ pt);
      exp_q.push_back(1'b1);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i == exp_q.size() - 1) begin
            Data_Valid = nxt_dv;
            P_DATA     = nb;
            PAR_EN     = npe;
            PAR_TYP    = npt;
         end else begin
            case (mode)
               0: Data_Valid = 1'b0;
               1: Data_Valid = 1'b1;
               2: begin
                  Data_Valid = 1'($urandom);
                  P_DATA     = 8'($urandom);
                  PAR_EN     = 1'($urandom);
                  PAR_TYP    = 1'($urandom);
               end
               default: begin
                  Data_Valid = 1'b0;
                  P_DATA     = 8'h00;
                  PAR_EN     = ~pe;
                  PAR_TYP    = ~pt;
               end
            endcase
         end
         @(negedge clk);
         check($sformatf("tx_%02h_bit%0d", b, i), TX_OUT, exp_q[i]);
         check($sformatf("busy_%02h_bit%0d", b, i), busy, 1'b1);
         check($sformatf("ser_en_%02h_bit%0d", b, i), ser_en, (i >= 1 && i <= 8) ? 1'b1 : 1'b0);
         check($sformatf("sdi_%02h_bit%0d", b, i), ser_data_in, b);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [7:0] b, nb;
      logic       pe, pt, npe, npt, chain;

      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         Data_Valid = 1'($urandom);
         P_DATA     = 8'($urandom);
         PAR_EN     = 1'($urandom);
         PAR_TYP    = 1'($urandom);
         #7;
         check("rst_tx", TX_OUT, 1'b1);
         check("rst_busy", busy, 1'b0);
         check("rst_ser_en", ser_en, 1'b0);
         check("rst_sdi", ser_data_in, 8'h00);
      end
      Data_Valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      idle_check(20, 8'h00);

      // Even parity 0xA5
      launch(8'hA5, 1'b1, 1'b0);
      frame(8'hA5, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
      idle_check(2, 8'hA5);

      // Odd parity 0x03 with inputs clobbered mid-frame
      launch(8'h03, 1'b1, 1'b1);
      frame(8'h03, 1'b1, 1'b1, 3, 1'b0, 8'h00, 1'b0, 1'b0);
      idle_check(2, 8'h03);

      // No parity 0xFF
      launch(8'hFF, 1'b0, 1'b0);
      frame(8'hFF, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
      idle_check(3, 8'hFF);

      // Back-to-back with Data_Valid held high
      launch(8'h55, 1'b0, 1'b0);
      frame(8'h55, 1'b0, 1'b0, 1, 1'b1, 8'h0F, 1'b0, 1'b0);
      frame(8'h0F, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b0);
      idle_check(2, 8'h0F);

      // Random frames with input noise, randomly chained back-to-back
      b  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      launch(b, pe, pt);
      for (int i = 0; i < 10; i++) begin
         nb    = 8'($urandom);
         npe   = 1'($urandom);
         npt   = 1'($urandom);
         chain = (i < 9) ? 1'($urandom) : 1'b0;
         frame(b, pe, pt, 2, chain, nb, npe, npt);
         if (!chain) begin
            idle_check(1, b);
            if (i < 9) launch(nb, npe, npt);
         end
         b  = nb;
         pe = npe;
         pt = npt;
      end

      // Reset during data bit 4 of 0xA5
      launch(8'hA5, 1'b0, 1'b0);
      Data_Valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
      end
      #2;
      check("pre_rst_ser_en", ser_en, 1'b1);
      rst = 1'b0;
      #1;
      check("midrst_tx", TX_OUT, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_ser_en", ser_en, 1'b0);
      check("midrst_sdi", ser_data_in, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      launch(8'h3C, 1'b0, 1'b0);
      frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
      idle_check(2, 8'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
